// File: rtl/fir4_avg_outbuf_if.sv
// Valid/ready output stream of the fir4 moving-average buffer.
// The master side presents the FIFO head and the slave side returns out_ready.
interface fir4_avg_outbuf_if #(
  parameter int W = 16
);
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/fir4_avg_outbuf.sv
// Output stage for the 4-tap moving-sum filter: warm-up discard, divide-by-4 scaling,
// and an overrun-counting FIFO. Define FIR4_AVG_ROUND_EN for round-half-up; truncates otherwise.
module fir4_avg_outbuf #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int DROP  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [W+1:0]            in_sum,
  fir4_avg_outbuf_if.master       out_if,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    warm,
  output logic                    ovf,
  output logic [7:0]              drop_cnt,
  input  logic                    clr_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (DROP > 1) ? $clog2(DROP) : 1;
`ifdef FIR4_AVG_ROUND_EN
  localparam logic [W+1:0] RND = (W+2)'(2);
`else
  localparam logic [W+1:0] RND = '0;
`endif

  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          warm_q, warm_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];

  logic [W-1:0]  avg;
  logic [AW:0]   lvl;
  logic          full, pop, push_req, push_ok, overrun;

  // Bits [W+1:2] of the (optionally rounded) sum are the arithmetic shift by two.
  assign avg      = W'((in_sum + RND) >> 2);
  assign lvl      = wr_q - rd_q;
  assign full     = (lvl == (AW+1)'(DEPTH));
  assign pop      = (lvl != '0) && out_if.out_ready;
  assign push_req = warm_q && in_valid;
  assign push_ok  = push_req && (!full || pop);
  assign overrun  = push_req && full && !pop;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    warm_d = warm_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    mem_d  = mem_q;

    if (!warm_q && in_valid) begin
      if (cnt_q == CW'(DROP - 1)) warm_d = 1'b1;
      else                        cnt_d  = cnt_q + 1'b1;
    end

    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = avg;
      wr_d = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;

    // A clear and an overrun on the same edge leave the flag set with one drop counted.
    if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
    if (overrun) begin
      ovf_d = 1'b1;
      if (drop_d != 8'hFF) drop_d = drop_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      warm_q <= (DROP == 0);
      ovf_q  <= 1'b0;
      drop_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      warm_q <= warm_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
      mem_q  <= mem_d;
    end
  end

  assign out_if.out_valid = (lvl != '0);
  assign out_if.out_data  = (lvl != '0) ? mem_q[rd_q[AW-1:0]] : '0;
  assign level            = lvl;
  assign warm             = warm_q;
  assign ovf              = ovf_q;
  assign drop_cnt         = drop_q;
endmodule

// File: tb/tb_fir4_avg_outbuf.sv
// Self-checking bench for fir4_avg_outbuf: directed corner sequences, a rounding vector
// table and a randomized phase, all compared against a queue-based reference model.
module tb_fir4_avg_outbuf;
  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int DROP  = 4;
`ifdef FIR4_AVG_ROUND_EN
  localparam int RND = 2;
`else
  localparam int RND = 0;
`endif

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [W+1:0]  in_sum;
  logic [$clog2(DEPTH):0] level;
  logic          warm;
  logic          ovf;
  logic [7:0]    drop_cnt;
  logic          clr_ovf;

  fir4_avg_outbuf_if #(.W(W)) out_if ();

  fir4_avg_outbuf #(.W(W), .DEPTH(DEPTH), .DROP(DROP)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_sum   (in_sum),
    .out_if   (out_if),
    .level    (level),
    .warm     (warm),
    .ovf      (ovf),
    .drop_cnt (drop_cnt),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: the FIFO is just a queue of expected averages.
  logic [W-1:0] mq[$];
  int m_wcnt = 0;
  bit m_warm = 1'b0;
  bit m_ovf  = 1'b0;
  int m_drop = 0;
  int cur_sum = 0;

  typedef struct {
    int           sum;
    logic [W-1:0] exp_avg;
  } vec_t;
  vec_t vecs[4];

  function automatic logic [W-1:0] refAvg(input int s);
    int num;
    int q;
    num = s + RND;
    q = num / 4;
    if (num < 0 && (num % 4) != 0) q = q - 1;
    return W'(q);
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    bit pop, push, over;
    if (reset) begin
      mq.delete();
      m_wcnt = 0;
      m_warm = (DROP == 0);
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      pop  = (mq.size() != 0) && out_if.out_ready;
      push = m_warm && in_valid;
      over = push && (mq.size() == DEPTH) && !pop;
      if (clr_ovf) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
      if (over) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      if (pop) void'(mq.pop_front());
      if (push && !over) mq.push_back(refAvg(cur_sum));
      if (!m_warm && in_valid) begin
        m_wcnt++;
        if (m_wcnt >= DROP) m_warm = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    checkVal("out_valid", int'(out_if.out_valid), int'(mq.size() != 0));
    checkVal("level", int'(level), mq.size());
    checkVal("warm", int'(warm), int'(m_warm));
    checkVal("ovf", int'(ovf), int'(m_ovf));
    checkVal("drop_cnt", int'(drop_cnt), m_drop);
    if (mq.size() != 0) checkVal("out_data", int'(out_if.out_data), int'(mq[0]));
  endtask

  task automatic applyStimulus(input logic r, input logic iv, input int s,
                               input logic rdy, input logic clr);
    reset            = r;
    in_valid         = iv;
    cur_sum          = s;
    in_sum           = (W+2)'(s);
    out_if.out_ready = rdy;
    clr_ovf          = clr;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  function automatic int randSum();
    return int'($urandom_range(262140)) - 131072;
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{6,       (RND != 0) ? 16'd2 : 16'd1};
    vecs[1] = '{-6,      (RND != 0) ? 16'hFFFF : 16'hFFFE};
    vecs[2] = '{131068,  16'h7FFF};
    vecs[3] = '{-131072, 16'h8000};

    reset = 1'b1; in_valid = 1'b0; in_sum = '0; out_if.out_ready = 1'b0; clr_ovf = 1'b0;

    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkVal("reset_out_data", int'(out_if.out_data), 0);
    checkVal("reset_warm", int'(warm), 0);

    // Warm-up discards the first four sums; the fifth shows up as 116/4.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 100 + 4 * k, 0, 0);
      checkVal("warmup_warm", int'(warm), (k == 3) ? 1 : 0);
      checkVal("warmup_level", int'(level), 0);
    end
    applyStimulus(0, 1, 116, 0, 0);
    checkVal("first_avg", int'(out_if.out_data), 29);
    checkVal("first_level", int'(level), 1);

    // Nine more sums with the consumer stalled: two of the ten are lost.
    for (int k = 5; k < 14; k++) applyStimulus(0, 1, 100 + 4 * k, 0, 0);
    checkVal("full_level", int'(level), 8);
    checkVal("full_ovf", int'(ovf), 1);
    checkVal("full_drop", int'(drop_cnt), 2);
    for (int i = 0; i < 8; i++) begin
      checkVal("drain_order", int'(out_if.out_data), 29 + i);
      applyStimulus(0, 0, 0, 1, 0);
    end
    checkVal("drained_valid", int'(out_if.out_valid), 0);

    for (int i = 0; i < 8; i++) applyStimulus(0, 1, randSum(), 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, randSum(), 1, 0);
      checkVal("pushpop_level", int'(level), 8);
      checkVal("pushpop_drop", int'(drop_cnt), 2);
    end

    applyStimulus(0, 0, 0, 0, 1);
    checkVal("clr_alone_ovf", int'(ovf), 0);
    checkVal("clr_alone_drop", int'(drop_cnt), 0);
    applyStimulus(0, 1, randSum(), 0, 1);
    checkVal("clr_collide_ovf", int'(ovf), 1);
    checkVal("clr_collide_drop", int'(drop_cnt), 1);

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0);
    checkVal("pre_reset_level", int'(level), 5);
    applyStimulus(1, 0, 0, 0, 0);
    checkVal("midreset_level", int'(level), 0);
    checkVal("midreset_valid", int'(out_if.out_valid), 0);
    checkVal("midreset_warm", int'(warm), 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, randSum(), 0, 0);
      checkVal("rewarm_warm", int'(warm), (k == 3) ? 1 : 0);
      checkVal("rewarm_level", int'(level), 0);
    end
    applyStimulus(0, 1, randSum(), 0, 0);
    checkVal("rewarm_first", int'(level), 1);
    applyStimulus(0, 0, 0, 1, 0);

    // Push into an empty FIFO with out_ready high: visible next cycle, popped the one after.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, vecs[i].sum, 1, 0);
      checkVal("round_valid", int'(out_if.out_valid), 1);
      checkVal("round_avg", int'(out_if.out_data), int'(vecs[i].exp_avg));
      applyStimulus(0, 0, 0, 1, 0);
    end

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(99) == 0), ($urandom_range(3) != 0), randSum(),
                    $urandom_range(1) == 1, ($urandom_range(19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir4_avg_outbuf.md
# fir4_avg_outbuf

Output stage that sits directly downstream of the 4-tap CSA moving-sum filter. It consumes the free-running (W+2)-bit sum stream. It discards the pipeline warm-up samples and scales each sum by 1/4 to form a W-bit moving average. Results are buffered in a small FIFO behind a valid/ready handshake, so a stalling consumer never backpressures the filter; overruns are counted and flagged.

## Interface
Parameters:
- W, 16, filter sample width; input sum is W+2 bits, output average is W bits
- DEPTH, 8, FIFO entries; power of two, at least 2
- DROP, 4, number of initial accepted sums discarded after reset; 0 disables warm-up

Ports (reset: reset, synchronous, active-high; clock: clk):
- clk  input  1  clock, all state updates on posedge
- reset  input  1  synchronous active-high reset
- in_valid  input  1  in_sum is a new filter output this cycle
- in_sum  input  W+2  two's-complement sum of 4 samples from the filter
- out_valid  output  1  FIFO head holds a valid average
- out_ready  input  1  consumer accepts the head this cycle
- out_data  output  W  two's-complement moving average at FIFO head
- level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- warm  output  1  warm-up complete; sums are now being stored
- ovf  output  1  sticky overrun flag
- drop_cnt  output  8  saturating count of sums lost to overrun
- clr_ovf  input  1  clears ovf and drop_cnt

## Operation
- Warm-up: a counter counts accepted in_valid cycles from reset.
  - The first DROP valid sums are discarded and do not count as overruns.
  - warm rises on the clock edge that consumes the DROP-th sum.
  - With DROP=0, warm is 1 on the first cycle after reset.
- Scaling: avg = (in_sum + 2) >>> 2, arithmetic shift, in W+2 bits, low W bits kept.
  - Full input range -4*2^(W-1)..4*(2^(W-1)-1) always maps into W bits, so no saturation logic is needed.
- FIFO: circular buffer, write and read pointers of $clog2(DEPTH)+1 bits, with a wrap bit for full/empty.
  - out_data is the head entry, show-ahead.
  - Pop when out_valid && out_ready.
  - Push when warm && in_valid.
- Full with push and no pop: the new sample is dropped, FIFO contents are unchanged, ovf is set, drop_cnt increments (saturates at 255).
- Full with push and pop in the same cycle: both occur, no drop, level unchanged.
- Empty with push and out_ready: no pop that cycle; the sample becomes visible next cycle.
- clr_ovf: clears ovf and drop_cnt on that edge.
  - If an overrun happens in the same cycle, the overrun wins: ovf=1, drop_cnt=1.
- out_ready while out_valid=0: ignored.

## Timing
- Reset values: out_valid=0, level=0, warm=(DROP==0), ovf=0, drop_cnt=0, out_data=0, pointers=0, warm-up count=0.
- Reset has priority over all other inputs. Reset mid-operation flushes the FIFO and restarts warm-up on the next edge.
- Latency: a sum accepted at edge N into an empty FIFO gives out_valid=1 and out_data=avg after edge N, so it is visible in cycle N+1.
- level updates on the same edge as push/pop.
- out_valid is equivalent to level!=0.
- out_data is stable while out_valid && !out_ready.
- Sustained throughput is one sample per cycle with out_ready held high.

## Configuration
- FIR4_AVG_ROUND_EN defined: the +2 round-half-up term is added before the shift, as described above.
- FIR4_AVG_ROUND_EN undefined: truncating average, avg = in_sum >>> 2 (floor toward minus infinity). All other behaviour is identical.

## Test plan
- Warm-up, with reset and then in_valid=1 streaming sums 100, 104, 108, …:
  - The first 4 sums are dropped; warm rises after the 4th.
  - The 5th sum (116) appears as out_data=29 one cycle later.
  - level never counts the dropped sums.
- Rounding, with out_ready=1 and sums 6, -6, 131068, -131072 (W=16):
  - With FIR4_AVG_ROUND_EN: 2, -1, 32767, -32768.
  - Without it: 1, -2, 32767, -32768.
- Full and overrun, with out_ready=0 and 10 post-warm-up sums:
  - level reaches 8 and stays there.
  - ovf=1, drop_cnt=2.
  - Draining yields exactly the first 8 averages, in order.
- Simultaneous push and pop when full, with out_ready=1 and in_valid=1 for 20 cycles:
  - level stays 8, no increment of drop_cnt.
  - Output order is preserved across pointer wrap.
- clr_ovf collision: pulse clr_ovf alone, then together with an overrun.
  - Alone: ovf=0, drop_cnt=0.
  - Together with an overrun: ovf=1, drop_cnt=1.
- Reset mid-stream, with the FIFO at level 5, out_valid=1:
  - Next cycle: level=0, out_valid=0, warm=0.
  - Warm-up restarts and requires 4 new sums.
